// File: rtl/xif_copro_commit_tracker.sv
// In-order commit/kill tracker for offloaded XIF instructions.
// Mirrors the input stream FIFO order and reports the oldest entry's commit state.
module xif_copro_commit_tracker #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  input  logic [ID_WIDTH-1:0]          issue_id_i,
  output logic                         ready_o,
  input  logic                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         head_valid_o,
  output logic [ID_WIDTH-1:0]          head_id_o,
  output logic                         head_committed_o,
  output logic                         head_killed_o,
  input  logic                         retire_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_commit_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ISSUED    = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } state_e;

  logic [ID_WIDTH-1:0] id_q [DEPTH];
  logic [ID_WIDTH-1:0] id_d [DEPTH];
  state_e              st_q [DEPTH];
  state_e              st_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  logic                ready_s;
  logic                head_valid_s;
  state_e              head_st_s;
  logic                push_s;
  logic                retire_s;
  logic                match_s;
  state_e              commit_st_s;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Next-state: commit matching, retire, push and occupancy update.
  always_comb begin
    id_d        = id_q;
    st_d        = st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    match_s     = 1'b0;
    ready_s     = (count_q < CNT_W'(DEPTH));
    head_valid_s = (count_q != {CNT_W{1'b0}});
    head_st_s   = st_q[rd_ptr_q];
    push_s      = issue_valid_i & ready_s;
    retire_s    = retire_i & head_valid_s & (head_st_s != ST_ISSUED);
    commit_st_s = commit_kill_i ? ST_KILLED : ST_COMMITTED;

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && (st_q[i] == ST_ISSUED) && (id_q[i] == commit_id_i)) begin
        st_d[i] = commit_st_s;
        match_s = 1'b1;
      end else begin
        st_d[i] = st_q[i];
      end
    end

    // Retired head is never ISSUED, so the commit loop cannot have touched it.
    if (retire_s) begin
      st_d[rd_ptr_q] = ST_FREE;
      rd_ptr_d       = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      id_d[wr_ptr_q] = issue_id_i;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
      if (commit_valid_i && (commit_id_i == issue_id_i)) begin
        st_d[wr_ptr_q] = commit_st_s;
        match_s        = 1'b1;
      end else begin
        st_d[wr_ptr_q] = ST_ISSUED;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, retire_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    err_d = commit_valid_i & ~match_s;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= {ID_WIDTH{1'b0}};
        st_q[i] <= ST_FREE;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      id_q     <= id_d;
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign ready_o          = ready_s;
  assign head_valid_o     = head_valid_s;
  assign head_id_o        = head_valid_s ? id_q[rd_ptr_q] : {ID_WIDTH{1'b0}};
  assign head_committed_o = head_valid_s & (head_st_s == ST_COMMITTED);
  assign head_killed_o    = head_valid_s & (head_st_s == ST_KILLED);
  assign count_o          = count_q;
  assign err_commit_o     = err_q;

endmodule

// File: tb/tb_xif_copro_commit_tracker.sv
// Self-checking bench for xif_copro_commit_tracker (DEPTH=4, ID_WIDTH=4).
// Accepted pushes go into a scoreboard queue; retired head IDs are popped and compared.
module tb_xif_copro_commit_tracker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       issue_valid_i;
  logic [3:0] issue_id_i;
  logic       ready_o;
  logic       commit_valid_i;
  logic [3:0] commit_id_i;
  logic       commit_kill_i;
  logic       head_valid_o;
  logic [3:0] head_id_o;
  logic       head_committed_o;
  logic       head_killed_o;
  logic       retire_i;
  logic [2:0] count_o;
  logic       err_commit_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  xif_copro_commit_tracker #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .issue_valid_i    (issue_valid_i),
    .issue_id_i       (issue_id_i),
    .ready_o          (ready_o),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .head_valid_o     (head_valid_o),
    .head_id_o        (head_id_o),
    .head_committed_o (head_committed_o),
    .head_killed_o    (head_killed_o),
    .retire_i         (retire_i),
    .count_o          (count_o),
    .err_commit_o     (err_commit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    retire_i       = 1'b0;
  endtask

  task automatic push_id(input logic [3:0] id);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    exp_q.push_back(id);
    tick();
  endtask

  task automatic commit_id(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
  endtask

  // Compare head against scoreboard, then raise retire for one cycle.
  task automatic sb_retire_arm();
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      check_eq("retire_id", {28'd0, head_id_o}, {28'd0, exp_q.pop_front()});
    end
    retire_i = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i          = 1'b1;
    issue_valid_i  = 1'b0;
    issue_id_i     = 4'd0;
    commit_valid_i = 1'b0;
    commit_id_i    = 4'd0;
    commit_kill_i  = 1'b0;
    retire_i       = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_count", {29'd0, count_o}, 32'd0);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
    check_eq("rst_hvalid", {31'd0, head_valid_o}, 32'd0);
    check_eq("rst_hid", {28'd0, head_id_o}, 32'd0);
    check_eq("rst_hflags", {30'd0, head_committed_o, head_killed_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_commit_o}, 32'd0);
    rst_i = 1'b0;

    // Push 3, commit it next cycle, retire.
    push_id(4'd3);
    check_eq("t1_hvalid", {31'd0, head_valid_o}, 32'd1);
    check_eq("t1_hid", {28'd0, head_id_o}, 32'd3);
    check_eq("t1_hcom_pre", {31'd0, head_committed_o}, 32'd0);
    commit_id(4'd3, 1'b0);
    check_eq("t1_hcom", {31'd0, head_committed_o}, 32'd1);
    check_eq("t1_err", {31'd0, err_commit_o}, 32'd0);
    sb_retire_arm();
    tick();
    check_eq("t1_count", {29'd0, count_o}, 32'd0);
    check_eq("t1_hvalid_end", {31'd0, head_valid_o}, 32'd0);

    // Fill, then push while full together with a retire: push dropped.
    push_id(4'd1);
    push_id(4'd2);
    push_id(4'd3);
    push_id(4'd4);
    check_eq("t2_ready_full", {31'd0, ready_o}, 32'd0);
    check_eq("t2_count_full", {29'd0, count_o}, 32'd4);
    commit_id(4'd1, 1'b0);
    issue_valid_i = 1'b1;
    issue_id_i    = 4'd5;
    sb_retire_arm();
    tick();
    check_eq("t2_count_drop", {29'd0, count_o}, 32'd3);
    check_eq("t2_ready", {31'd0, ready_o}, 32'd1);
    check_eq("t2_hid", {28'd0, head_id_o}, 32'd2);
    commit_id(4'd2, 1'b0);
    commit_id(4'd3, 1'b0);
    commit_id(4'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sb_retire_arm();
      tick();
    end
    check_eq("t2_count_end", {29'd0, count_o}, 32'd0);

    // Same-cycle push and kill of ID 7.
    issue_valid_i  = 1'b1;
    issue_id_i     = 4'd7;
    exp_q.push_back(4'd7);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd7;
    commit_kill_i  = 1'b1;
    tick();
    check_eq("t3_hkill", {31'd0, head_killed_o}, 32'd1);
    check_eq("t3_hcom", {31'd0, head_committed_o}, 32'd0);
    check_eq("t3_err", {31'd0, err_commit_o}, 32'd0);
    sb_retire_arm();
    tick();
    check_eq("t3_count", {29'd0, count_o}, 32'd0);

    // Unmatched commit ID 9 with one ISSUED entry present.
    push_id(4'd6);
    commit_id(4'd9, 1'b0);
    check_eq("t4_err", {31'd0, err_commit_o}, 32'd1);
    check_eq("t4_hcom", {31'd0, head_committed_o}, 32'd0);
    check_eq("t4_count", {29'd0, count_o}, 32'd1);
    tick();
    check_eq("t4_err_clr", {31'd0, err_commit_o}, 32'd0);
    commit_id(4'd6, 1'b0);
    check_eq("t4_hcom6", {31'd0, head_committed_o}, 32'd1);
    sb_retire_arm();
    tick();

    // Out-of-order commits; retire held high stalls until head committed.
    push_id(4'd1);
    push_id(4'd2);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd2;
    retire_i       = 1'b1;
    tick();
    check_eq("t5_stall_count", {29'd0, count_o}, 32'd2);
    check_eq("t5_stall_hid", {28'd0, head_id_o}, 32'd1);
    check_eq("t5_stall_hcom", {31'd0, head_committed_o}, 32'd0);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd1;
    retire_i       = 1'b1;
    tick();
    check_eq("t5_count_c1", {29'd0, count_o}, 32'd2);
    check_eq("t5_hcom1", {31'd0, head_committed_o}, 32'd1);
    sb_retire_arm();
    tick();
    check_eq("t5_count_r1", {29'd0, count_o}, 32'd1);
    sb_retire_arm();
    tick();
    check_eq("t5_count_r2", {29'd0, count_o}, 32'd0);

    // Asynchronous reset between clock edges discards entries.
    push_id(4'd1);
    push_id(4'd2);
    push_id(4'd3);
    check_eq("t6_count_pre", {29'd0, count_o}, 32'd3);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("t6_async_count", {29'd0, count_o}, 32'd0);
    check_eq("t6_async_hvalid", {31'd0, head_valid_o}, 32'd0);
    check_eq("t6_async_ready", {31'd0, ready_o}, 32'd1);
    exp_q.delete();
    #1;
    rst_i = 1'b0;
    tick();
    check_eq("t6_post_count", {29'd0, count_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
